// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART command controller.
package uart_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CMD       = 3'd1,
      ST_PAYLOAD   = 3'd2,
      ST_CHECK     = 3'd3,
      ST_ISSUE     = 3'd4,
      ST_WAIT_DONE = 3'd5
   } ctrl_state_t;

   localparam logic [7:0] CMD_MUL      = 8'h01;
   localparam logic [7:0] CMD_SET_BAUD = 8'h02;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_CMD     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [1:0] BAUD_9600 = 2'b00;
   localparam logic [1:0] BAUD_115K = 2'b01;
   localparam logic [1:0] BAUD_1M   = 2'b10;
   localparam logic [1:0] BAUD_4M   = 2'b11;

endpackage

// File: rtl/uart_byte_strobe.sv
// Turns the level-held receiver valid into a one-cycle byte strobe and keeps
// the most recently accepted byte.
module uart_byte_strobe (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_valid,
   input  logic [7:0] rx_data,
   output logic       byte_stb,
   output logic [7:0] byte_data
);

   logic       rx_valid_q, rx_valid_d;
   logic [7:0] data_q, data_d;

   // byte_data is rx_data on the strobe cycle itself, otherwise the held copy
   always_comb begin
      rx_valid_d = rx_valid;
      byte_stb   = rx_valid & ~rx_valid_q;
      data_d     = byte_stb ? rx_data : data_q;
      byte_data  = data_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_valid_q <= 1'b0;
         data_q     <= '0;
      end else begin
         rx_valid_q <= rx_valid_d;
         data_q     <= data_d;
      end
   end

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Frame parser behind the UART receiver: runs MUL commands through the
// multiplier and owns the receiver baud select register.
module uart_cmd_ctrl
   import uart_ctrl_pkg::*;
#(
   parameter int unsigned OP_WIDTH       = 8,
   parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
   input  logic                  uart_clock,
   input  logic                  uart_reset,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [1:0]            freq_control,
   output logic [OP_WIDTH-1:0]   mul_a,
   output logic [OP_WIDTH-1:0]   mul_b,
   output logic                  mul_start,
   input  logic                  mul_done,
   input  logic [2*OP_WIDTH-1:0] mul_result,
   output logic [2*OP_WIDTH-1:0] result,
   output logic                  result_valid,
   output logic                  busy,
   output logic [1:0]            err_code,
   output logic                  err_pulse
);

   localparam int unsigned OP_BYTES = OP_WIDTH / 8;
   localparam int unsigned CNT_W    = $clog2(2 * OP_BYTES) + 1;
   localparam logic [CNT_W-1:0] NEED_MUL  = CNT_W'(2 * OP_BYTES);
   localparam logic [CNT_W-1:0] NEED_BAUD = CNT_W'(1);
   localparam logic [23:0]      TMO_LAST  = TIMEOUT_CYCLES - 24'd1;

   logic       byte_stb;
   logic [7:0] byte_data;

   uart_byte_strobe u_byte_strobe (
      .clk       (uart_clock),
      .rst_n     (uart_reset),
      .rx_valid  (rx_valid),
      .rx_data   (rx_data),
      .byte_stb  (byte_stb),
      .byte_data (byte_data)
   );

   ctrl_state_t           state_q, state_d;
   logic [7:0]            cmd_q, cmd_d;
   logic [7:0]            csum_q, csum_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [2*OP_WIDTH-1:0] shreg_q, shreg_d;
   logic [1:0]            baud_byte_q, baud_byte_d;
   logic [23:0]           tmo_q, tmo_d;
   logic [1:0]            freq_q, freq_d;
   logic [OP_WIDTH-1:0]   mul_a_q, mul_a_d;
   logic [OP_WIDTH-1:0]   mul_b_q, mul_b_d;
   logic                  mul_start_q, mul_start_d;
   logic [2*OP_WIDTH-1:0] result_q, result_d;
   logic                  result_valid_q, result_valid_d;
   logic [1:0]            err_code_q, err_code_d;
   logic                  err_pulse_q, err_pulse_d;
   logic [CNT_W-1:0]      need;
   logic                  tmo_hit;

   always_comb begin
      state_d        = state_q;
      cmd_d          = cmd_q;
      csum_d         = csum_q;
      cnt_d          = cnt_q;
      shreg_d        = shreg_q;
      baud_byte_d    = baud_byte_q;
      freq_d         = freq_q;
      mul_a_d        = mul_a_q;
      mul_b_d        = mul_b_q;
      mul_start_d    = 1'b0;
      result_d       = result_q;
      result_valid_d = 1'b0;
      err_code_d     = err_code_q;
      err_pulse_d    = 1'b0;
      need           = (cmd_q == CMD_MUL) ? NEED_MUL : NEED_BAUD;
      tmo_hit        = (tmo_q == TMO_LAST);

      case (state_q)
         ST_IDLE: begin
            if (byte_stb && byte_data == SYNC_BYTE) begin
               state_d = ST_CMD;
               csum_d  = '0;
            end
         end
         ST_CMD: begin
            if (byte_stb) begin
               cmd_d  = byte_data;
               csum_d = byte_data;
               cnt_d  = '0;
               if (byte_data == CMD_MUL || byte_data == CMD_SET_BAUD) begin
                  state_d = ST_PAYLOAD;
               end else begin
                  err_code_d  = ERR_CMD;
                  err_pulse_d = 1'b1;
                  state_d     = ST_IDLE;
               end
            end else if (tmo_hit) begin
               err_code_d  = ERR_TIMEOUT;
               err_pulse_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_PAYLOAD: begin
            if (byte_stb) begin
               csum_d = csum_q ^ byte_data;
               cnt_d  = cnt_q + CNT_W'(1);
               if (cmd_q == CMD_MUL) shreg_d = {shreg_q[2*OP_WIDTH-9:0], byte_data};
               else                  baud_byte_d = byte_data[1:0];
               if (cnt_q == need - CNT_W'(1)) state_d = ST_CHECK;
            end else if (tmo_hit) begin
               err_code_d  = ERR_TIMEOUT;
               err_pulse_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_CHECK: begin
            if (byte_stb) begin
               if (byte_data != csum_q) begin
                  err_code_d  = ERR_CSUM;
                  err_pulse_d = 1'b1;
                  state_d     = ST_IDLE;
               end else if (cmd_q == CMD_SET_BAUD) begin
                  freq_d  = baud_byte_q;
                  state_d = ST_IDLE;
               end else begin
                  mul_a_d = shreg_q[2*OP_WIDTH-1:OP_WIDTH];
                  mul_b_d = shreg_q[OP_WIDTH-1:0];
                  state_d = ST_ISSUE;
               end
            end else if (tmo_hit) begin
               err_code_d  = ERR_TIMEOUT;
               err_pulse_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            mul_start_d = 1'b1;
            state_d     = ST_WAIT_DONE;
            if (byte_stb) begin
               err_code_d  = ERR_TIMEOUT;
               err_pulse_d = 1'b1;
            end
         end
         ST_WAIT_DONE: begin
            // an overrun byte is reported but does not abandon the multiply
            if (byte_stb) begin
               err_code_d  = ERR_TIMEOUT;
               err_pulse_d = 1'b1;
            end
            if (mul_done) begin
               result_d       = mul_result;
               result_valid_d = 1'b1;
               state_d        = ST_IDLE;
            end else if (!byte_stb && tmo_hit) begin
               err_code_d  = ERR_TIMEOUT;
               err_pulse_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (byte_stb || state_d != state_q) tmo_d = '0;
      else if (state_q == ST_CMD || state_q == ST_PAYLOAD ||
               state_q == ST_CHECK || state_q == ST_WAIT_DONE) tmo_d = tmo_q + 24'd1;
      else tmo_d = '0;
   end

   always_ff @(posedge uart_clock or negedge uart_reset) begin
      if (!uart_reset) begin
         state_q        <= ST_IDLE;
         cmd_q          <= '0;
         csum_q         <= '0;
         cnt_q          <= '0;
         shreg_q        <= '0;
         baud_byte_q    <= '0;
         tmo_q          <= '0;
         freq_q         <= BAUD_9600;
         mul_a_q        <= '0;
         mul_b_q        <= '0;
         mul_start_q    <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         err_code_q     <= ERR_NONE;
         err_pulse_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         cmd_q          <= cmd_d;
         csum_q         <= csum_d;
         cnt_q          <= cnt_d;
         shreg_q        <= shreg_d;
         baud_byte_q    <= baud_byte_d;
         tmo_q          <= tmo_d;
         freq_q         <= freq_d;
         mul_a_q        <= mul_a_d;
         mul_b_q        <= mul_b_d;
         mul_start_q    <= mul_start_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         err_code_q     <= err_code_d;
         err_pulse_q    <= err_pulse_d;
      end
   end

   assign freq_control = freq_q;
   assign mul_a        = mul_a_q;
   assign mul_b        = mul_b_q;
   assign mul_start    = mul_start_q;
   assign result       = result_q;
   assign result_valid = result_valid_q;
   assign busy         = (state_q != ST_IDLE);
   assign err_code     = err_code_q;
   assign err_pulse    = err_pulse_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: directed frames plus randomized
// frames, checked against a frame-level reference model.
module tb_uart_cmd_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_valid = 1'b0;
   logic [1:0]  freq_control;
   logic [7:0]  mul_a, mul_b;
   logic        mul_start;
   logic        mul_done = 1'b0;
   logic [15:0] mul_result = '0;
   logic [15:0] result;
   logic        result_valid, busy, err_pulse;
   logic [1:0]  err_code;

   always #5 clk = ~clk;

   uart_cmd_ctrl #(
      .OP_WIDTH       (8),
      .SYNC_BYTE      (8'hA5),
      .TIMEOUT_CYCLES (24'd100)
   ) dut (
      .uart_clock   (clk),
      .uart_reset   (rst_n),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .freq_control (freq_control),
      .mul_a        (mul_a),
      .mul_b        (mul_b),
      .mul_start    (mul_start),
      .mul_done     (mul_done),
      .mul_result   (mul_result),
      .result       (result),
      .result_valid (result_valid),
      .busy         (busy),
      .err_code     (err_code),
      .err_pulse    (err_pulse)
   );

   int unsigned total = 0, bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Frame-level expectations
   logic [1:0]  exp_freq = '0;
   logic [7:0]  exp_a = '0, exp_b = '0;
   logic [15:0] exp_res = '0;
   logic [1:0]  exp_err = '0;
   int unsigned exp_starts = 0, exp_rv = 0, exp_errs = 0;

   // Observed pulse counts, sampled mid-cycle
   int unsigned n_start = 0, n_rv = 0, n_err = 0;
   always @(negedge clk) begin
      if (mul_start)    n_start++;
      if (result_valid) n_rv++;
      if (err_pulse)    n_err++;
   end

   // Behavioural multiplier: answers each start after mul_delay cycles
   int unsigned mul_delay = 2;
   logic        mul_hold = 1'b0;
   initial begin
      logic [7:0] pa, pb;
      forever begin
         @(negedge clk);
         if (mul_start && !mul_hold) begin
            pa = mul_a;
            pb = mul_b;
            repeat (mul_delay) @(negedge clk);
            mul_done   = 1'b1;
            mul_result = 16'(pa) * 16'(pb);
            @(negedge clk);
            mul_done   = 1'b0;
            mul_result = 16'($urandom);
         end
      end
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick(2);
      rx_valid = 1'b0;
      rx_data  = 8'($urandom);
      tick(1);
   endtask

   task automatic send_junk(input int unsigned n);
      logic [7:0] j;
      for (int unsigned i = 0; i < n; i++) begin
         j = 8'($urandom);
         if (j == 8'hA5) j = 8'h5A;
         send_byte(j);
      end
   endtask

   task automatic send_mul(input logic [7:0] a, input logic [7:0] b, input logic corrupt);
      logic [7:0] cs;
      cs = 8'h01 ^ a ^ b;
      if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
      send_byte(8'hA5); send_byte(8'h01); send_byte(a); send_byte(b); send_byte(cs);
      if (corrupt) begin
         exp_err = 2'd1;
         exp_errs++;
      end else begin
         exp_a = a; exp_b = b; exp_res = 16'(a) * 16'(b);
         exp_starts++; exp_rv++;
      end
   endtask

   task automatic send_baud(input logic [7:0] p, input logic corrupt);
      logic [7:0] cs;
      cs = 8'h02 ^ p;
      if (corrupt) cs = cs ^ 8'($urandom_range(1, 255));
      send_byte(8'hA5); send_byte(8'h02); send_byte(p); send_byte(cs);
      if (corrupt) begin
         exp_err = 2'd1;
         exp_errs++;
      end else begin
         exp_freq = p[1:0];
      end
   endtask

   task automatic wait_idle();
      for (int unsigned i = 0; i < 400; i++) begin
         if (!busy) break;
         tick(1);
      end
      chk("idle_wait", busy, 1'b0);
      tick(2);
   endtask

   task automatic check_all(input string t);
      chk({t, ":freq"},   freq_control, exp_freq);
      chk({t, ":mul_a"},  mul_a, exp_a);
      chk({t, ":mul_b"},  mul_b, exp_b);
      chk({t, ":result"}, result, exp_res);
      chk({t, ":err"},    err_code, exp_err);
      chk({t, ":starts"}, n_start, exp_starts);
      chk({t, ":rvalid"}, n_rv, exp_rv);
      chk({t, ":errps"},  n_err, exp_errs);
      chk({t, ":busy"},   busy, 1'b0);
   endtask

   task automatic check_reset_vals(input string t);
      chk({t, ":freq"},   freq_control, 2'b00);
      chk({t, ":mul_a"},  mul_a, 8'h00);
      chk({t, ":mul_b"},  mul_b, 8'h00);
      chk({t, ":result"}, result, 16'h0000);
      chk({t, ":start"},  mul_start, 1'b0);
      chk({t, ":rvalid"}, result_valid, 1'b0);
      chk({t, ":busy"},   busy, 1'b0);
      chk({t, ":err"},    err_code, 2'd0);
      chk({t, ":errp"},   err_pulse, 1'b0);
   endtask

   task automatic model_reset();
      exp_freq = '0; exp_a = '0; exp_b = '0; exp_res = '0; exp_err = '0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] a, b, p, c;
      int unsigned kind;

      tick(3);
      check_reset_vals("reset");
      rst_n = 1'b1;
      tick(2);

      // Directed MUL
      send_mul(8'h0C, 8'h0D, 1'b0);
      wait_idle();
      check_all("mul_0c0d");
      chk("mul_0c0d:res_val", result, 16'h009C);

      // Sync byte values inside payload are plain data
      send_mul(8'hA5, 8'hA5, 1'b0);
      wait_idle();
      check_all("mul_a5a5");

      // Baud changes only once the checksum byte is accepted
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h03);
      chk("baud_mid:freq", freq_control, 2'b00);
      send_byte(8'h01);
      exp_freq = 2'b11;
      tick(1);
      check_all("baud_11");
      send_baud(8'h01, 1'b0);
      wait_idle();
      check_all("baud_01");

      // Bad checksum
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'hFF);
      exp_err = 2'd1; exp_errs++;
      wait_idle();
      check_all("bad_csum");

      // Junk then unknown command, then a good frame
      send_byte(8'h33);
      chk("junk:busy", busy, 1'b0);
      send_byte(8'hA5); send_byte(8'h7E);
      exp_err = 2'd2; exp_errs++;
      wait_idle();
      check_all("bad_cmd");
      send_mul(8'h11, 8'h22, 1'b0);
      wait_idle();
      check_all("after_bad_cmd");

      // Inter-byte timeout: fires exactly 100 cycles after the last byte
      send_byte(8'hA5); send_byte(8'h01);
      tick(97);
      chk("tmo_early:errp", err_pulse, 1'b0);
      chk("tmo_early:busy", busy, 1'b1);
      tick(1);
      chk("tmo_fire:errp", err_pulse, 1'b1);
      chk("tmo_fire:err", err_code, 2'd3);
      exp_err = 2'd3; exp_errs++;
      tick(2);
      check_all("tmo_payload");

      // Multiplier never answers
      mul_hold = 1'b1;
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h09); send_byte(8'h01 ^ 8'h07 ^ 8'h09);
      exp_a = 8'h07; exp_b = 8'h09; exp_starts++;
      exp_err = 2'd3; exp_errs++;
      wait_idle();
      check_all("tmo_wait_done");
      mul_hold = 1'b0;

      // Overrun during WAIT_DONE still latches the pending product
      mul_delay = 20;
      send_mul(8'h5A, 8'h3C, 1'b0);
      send_byte(8'h11);
      exp_err = 2'd3; exp_errs++;
      wait_idle();
      check_all("overrun");

      // Asynchronous reset mid-frame
      send_byte(8'hA5); send_byte(8'h01); send_byte(8'h05);
      #3 rst_n = 1'b0;
      #1 check_reset_vals("rst_frame");
      model_reset();
      tick(2);
      rst_n = 1'b1;
      tick(2);

      // Reset while the multiplier is in flight; its late done is ignored
      mul_delay = 30;
      send_mul(8'h0F, 8'h0E, 1'b0);
      exp_rv--;
      #3 rst_n = 1'b0;
      #1 check_reset_vals("rst_mul");
      model_reset();
      tick(2);
      rst_n = 1'b1;
      tick(40);
      check_all("rst_mul_after");

      // Randomized frames
      for (int unsigned it = 0; it < 40; it++) begin
         mul_delay = $urandom_range(0, 8);
         send_junk($urandom_range(0, 2));
         kind = $urandom_range(0, 4);
         a = 8'($urandom); b = 8'($urandom); p = 8'($urandom);
         case (kind)
            0, 1: send_mul(a, b, 1'b0);
            2:    send_baud(p, 1'b0);
            3: begin
               if (p[0]) send_mul(a, b, 1'b1);
               else      send_baud(p, 1'b1);
            end
            default: begin
               c = 8'($urandom);
               if (c == 8'h01 || c == 8'h02) c = 8'h7E;
               send_byte(8'hA5); send_byte(c);
               exp_err = 2'd2; exp_errs++;
            end
         endcase
         wait_idle();
         check_all($sformatf("rand%0d", it));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
